// File: rtl/vscale_dmem_responder_pkg.sv
// Shared constants for the data-memory responder: access size codes and FSM states.
package vscale_dmem_responder_pkg;

  localparam int MEM_TYPE_WIDTH = 3;

  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_B  = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_H  = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_W  = 3'd2;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_BU = 3'd4;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/vscale_dmem_responder_lane.sv
// Byte-lane steering for the data-memory responder: store byte enables and
// replicated store data, plus lane selection and sign/zero extension of loads.
module vscale_dmem_responder_lane
  import vscale_dmem_responder_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wmerged,
  output logic [31:0] rext
);

  logic [31:0] shifted_s;

  // Store side: replicate the narrow value into every lane and enable only the addressed bytes.
  always_comb begin
    byte_en = 4'b0000;
    wmerged = wdata;
    case (size)
      MEM_TYPE_B, MEM_TYPE_BU: begin
        byte_en = 4'b0001 << addr_lo;
        wmerged = {4{wdata[7:0]}};
      end
      MEM_TYPE_H, MEM_TYPE_HU: begin
        byte_en = 4'b0011 << {addr_lo[1], 1'b0};
        wmerged = {2{wdata[15:0]}};
      end
      MEM_TYPE_W: begin
        byte_en = 4'b1111;
        wmerged = wdata;
      end
      default: begin
        byte_en = 4'b0000;
        wmerged = wdata;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend to a full word.
  always_comb begin
    shifted_s = rword >> {addr_lo, 3'b000};
    rext      = 32'h0000_0000;
    case (size)
      MEM_TYPE_B:  rext = {{24{shifted_s[7]}}, shifted_s[7:0]};
      MEM_TYPE_BU: rext = {24'h00_0000, shifted_s[7:0]};
      MEM_TYPE_H:  rext = {{16{shifted_s[15]}}, shifted_s[15:0]};
      MEM_TYPE_HU: rext = {16'h0000, shifted_s[15:0]};
      MEM_TYPE_W:  rext = rword;
      default:     rext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Target-side responder for the core's two-phase data-memory interface.
// Address phase is latched, optional wait states stretch the data phase, and the
// access completes in the DATA cycle against a word-organised SRAM.
// Optional build macro VSCALE_DMEM_TOHOST_EN adds a tohost mailbox register.
module vscale_dmem_responder
  import vscale_dmem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
`ifdef VSCALE_DMEM_TOHOST_EN
  , parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
`ifdef VSCALE_DMEM_TOHOST_EN
  , output logic [31:0] tohost_data,
  output logic        tohost_valid
`endif
);

  localparam int          DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  // Alignment, range and size-code check on an address-phase request.
  function automatic logic calc_fault(input logic [2:0] size, input logic [31:0] addr);
    logic [31:0] off;
    logic        bad;
    off = addr - BASE_ADDR;
    bad = ((off >> (ADDR_WIDTH + 2)) != 32'h0000_0000);
    case (size)
      MEM_TYPE_B, MEM_TYPE_BU: bad = bad;
      MEM_TYPE_H, MEM_TYPE_HU: bad = bad | addr[0];
      MEM_TYPE_W:              bad = bad | (addr[1:0] != 2'b00);
      default:                 bad = 1'b1;
    endcase
    return bad;
  endfunction

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wait_q, wait_d;
  logic        wen_q, wen_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic        fault_q, fault_d;

  logic [31:0] mem_q [0:DEPTH-1];

  logic                  capture_s;
  logic                  data_s;
  logic [ADDR_WIDTH-1:0] widx_s;
  logic [31:0]           rword_s;
  logic [3:0]            byte_en_s;
  logic [31:0]           wmerged_s;
  logic [31:0]           rext_s;
  logic                  bypass_s;
  logic                  mem_we_s;

  assign capture_s = dmem_en & ~wait_q;
  assign data_s    = (state_q == ST_DATA);
  assign widx_s    = ADDR_WIDTH'((addr_q - BASE_ADDR) >> 2);

  // Next-state logic: capture requests when not stalling and sequence WAIT/DATA.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    wen_d   = wen_q;
    size_d  = size_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (capture_s) begin
          wen_d   = dmem_wen;
          size_d  = dmem_size;
          addr_d  = dmem_addr;
          fault_d = calc_fault(dmem_size, dmem_addr);
          if (WAIT_LOAD == 4'd0) begin
            state_d = ST_DATA;
            cnt_d   = 4'd0;
            wait_d  = 1'b0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
            wait_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          wait_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
          wait_d  = 1'b0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - 4'd1;
          wait_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        wait_d  = 1'b0;
      end
    endcase
  end

  // FSM, wait counter and latched request; reset drops any pending access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wait_q  <= 1'b0;
      wen_q   <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

`ifdef VSCALE_DMEM_TOHOST_EN
  logic [31:0] tohost_data_q, tohost_data_d;
  logic        tohost_valid_q, tohost_valid_d;

  assign bypass_s = data_s & wen_q & ~fault_q & ~reset &
                    (size_q == MEM_TYPE_W) & (addr_q == TOHOST_ADDR);
  assign rword_s  = (addr_q[31:2] == TOHOST_ADDR[31:2]) ? tohost_data_q : mem_q[widx_s];

  // Mailbox next value: captured only on a clean word store to the tohost address.
  always_comb begin
    tohost_valid_d = bypass_s;
    if (bypass_s) begin
      tohost_data_d = dmem_wdata_delayed;
    end else begin
      tohost_data_d = tohost_data_q;
    end
  end

  // Mailbox registers; valid pulses in the cycle after the store's DATA cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tohost_data_q  <= 32'h0000_0000;
      tohost_valid_q <= 1'b0;
    end else begin
      tohost_data_q  <= tohost_data_d;
      tohost_valid_q <= tohost_valid_d;
    end
  end

  assign tohost_data  = tohost_data_q;
  assign tohost_valid = tohost_valid_q;
`else
  assign bypass_s = 1'b0;
  assign rword_s  = mem_q[widx_s];
`endif

  vscale_dmem_responder_lane u_lane (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wdata   (dmem_wdata_delayed),
    .rword   (rword_s),
    .byte_en (byte_en_s),
    .wmerged (wmerged_s),
    .rext    (rext_s)
  );

  assign mem_we_s = data_s & wen_q & ~fault_q & ~reset & ~bypass_s;

  // Byte-enabled array write at the end of a clean store's DATA cycle.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_q[widx_s][8*i +: 8] <= wmerged_s[8*i +: 8];
        end
      end
    end
  end

  // Data-phase outputs; forced low outside DATA, on faults and while reset is held.
  always_comb begin
    dmem_wait     = wait_q & ~reset;
    dmem_badmem_e = data_s & fault_q & ~reset;
    if (data_s & ~wen_q & ~fault_q & ~reset) begin
      dmem_rdata = rext_s;
    end else begin
      dmem_rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Directed bench: one responder with no wait states, one with three.
module tb_vscale_dmem_responder;
  import vscale_dmem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en0, wen0, wait0, bad0;
  logic [2:0]  size0;
  logic [31:0] addr0, wd0, rd0;
  logic        en3, wen3, wait3, bad3;
  logic [2:0]  size3;
  logic [31:0] addr3, wd3, rd3;
`ifdef VSCALE_DMEM_TOHOST_EN
  logic [31:0] thd0, thd3;
  logic        thv0, thv3;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  vscale_dmem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .dmem_en(en0), .dmem_wen(wen0), .dmem_size(size0),
    .dmem_addr(addr0), .dmem_wdata_delayed(wd0), .dmem_rdata(rd0), .dmem_wait(wait0),
    .dmem_badmem_e(bad0)
`ifdef VSCALE_DMEM_TOHOST_EN
    , .tohost_data(thd0), .tohost_valid(thv0)
`endif
  );

  vscale_dmem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .dmem_en(en3), .dmem_wen(wen3), .dmem_size(size3),
    .dmem_addr(addr3), .dmem_wdata_delayed(wd3), .dmem_rdata(rd3), .dmem_wait(wait3),
    .dmem_badmem_e(bad3)
`ifdef VSCALE_DMEM_TOHOST_EN
    , .tohost_data(thd3), .tohost_valid(thv3)
`endif
  );

  // Single non-pipelined access on the zero-wait responder; samples its data phase.
  task automatic acc0(input logic w, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic bd);
    @(negedge clk);
    en0 = 1'b1; wen0 = w; size0 = sz; addr0 = a;
    @(negedge clk);
    en0 = 1'b0; wd0 = d;
    #1;
    rd = rd0; bd = bad0;
  endtask

  // Single access on the three-wait responder; counts wait cycles (bounded).
  task automatic acc3(input logic w, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic bd,
                      output int nw);
    @(negedge clk);
    en3 = 1'b1; wen3 = w; size3 = sz; addr3 = a;
    @(negedge clk);
    en3 = 1'b0; wd3 = d; nw = 0;
    #1;
    while (wait3 === 1'b1 && nw < 20) begin
      nw++;
      @(negedge clk);
      #1;
    end
    rd = rd3; bd = bad3;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    en0 = 1'b0; wen0 = 1'b0; size0 = 3'd0; addr0 = 32'h0; wd0 = 32'h0;
    en3 = 1'b0; wen3 = 1'b0; size3 = 3'd0; addr3 = 32'h0; wd3 = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({rd0, wait0, bad0} !== 34'h0) begin
      n_fail++; $display("FAIL reset_dut0: got rdata=%h wait=%b bad=%b, want all 0", rd0, wait0, bad0);
    end
    n_cmp++;
    if ({rd3, wait3, bad3} !== 34'h0) begin
      n_fail++; $display("FAIL reset_dut3: got rdata=%h wait=%b bad=%b, want all 0", rd3, wait3, bad3);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rd0, wait0, bad0} !== 34'h0) begin
      n_fail++; $display("FAIL idle_dut0: got rdata=%h wait=%b bad=%b, want all 0", rd0, wait0, bad0);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    en0 = 1'b1; wen0 = 1'b1; size0 = MEM_TYPE_W; addr0 = 32'h10;
    @(negedge clk);
    wd0 = 32'hDEAD_BEEF; wen0 = 1'b0; addr0 = 32'h10;
    #1;
    n_cmp++;
    if ({wait0, bad0} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_sw_phase: got wait=%b bad=%b, want 0 0", wait0, bad0);
    end
    @(negedge clk);
    en0 = 1'b0;
    #1;
    n_cmp++;
    if (rd0 !== 32'hDEAD_BEEF || wait0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_lw_data: got rdata=%h wait=%b, want deadbeef 0", rd0, wait0);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rd0 !== 32'h0 || wait0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got rdata=%h wait=%b, want 0 0", rd0, wait0);
    end
  endtask

  task automatic test_load_lanes;
    logic [2:0]  sz  [4];
    logic [31:0] ad  [4];
    logic [31:0] exp_v [4];
    logic [31:0] rd;
    logic        bd;
    sz[0] = MEM_TYPE_B;  ad[0] = 32'h13; exp_v[0] = 32'hFFFF_FFDE;
    sz[1] = MEM_TYPE_BU; ad[1] = 32'h13; exp_v[1] = 32'h0000_00DE;
    sz[2] = MEM_TYPE_H;  ad[2] = 32'h12; exp_v[2] = 32'hFFFF_DEAD;
    sz[3] = MEM_TYPE_HU; ad[3] = 32'h10; exp_v[3] = 32'h0000_BEEF;
    for (int i = 0; i < 4; i++) begin
      acc0(1'b0, sz[i], ad[i], 32'h0, rd, bd);
      n_cmp++;
      if (rd !== exp_v[i] || bd !== 1'b0) begin
        n_fail++; $display("FAIL load_lane_%0d: got rdata=%h bad=%b, want %h 0", i, rd, bd, exp_v[i]);
      end
    end
  endtask

  task automatic test_store_byte;
    logic [31:0] rd;
    logic        bd;
    acc0(1'b1, MEM_TYPE_B, 32'h11, 32'h0000_005A, rd, bd);
    acc0(1'b0, MEM_TYPE_W, 32'h10, 32'h0, rd, bd);
    n_cmp++;
    if (rd !== 32'hDEAD_5AEF) begin
      n_fail++; $display("FAIL sb_merge: got rdata=%h, want dead5aef", rd);
    end
    acc0(1'b1, MEM_TYPE_W, 32'h1000, 32'h0BAD_F00D, rd, bd);
    acc0(1'b0, MEM_TYPE_W, 32'h1000, 32'h0, rd, bd);
    n_cmp++;
    if (rd !== 32'h0BAD_F00D || bd !== 1'b0) begin
      n_fail++; $display("FAIL sw_1000: got rdata=%h bad=%b, want 0badf00d 0", rd, bd);
    end
    acc0(1'b1, MEM_TYPE_W, 32'h3FFC, 32'h1357_9BDF, rd, bd);
    acc0(1'b0, MEM_TYPE_W, 32'h3FFC, 32'h0, rd, bd);
    n_cmp++;
    if (rd !== 32'h1357_9BDF || bd !== 1'b0) begin
      n_fail++; $display("FAIL top_word: got rdata=%h bad=%b, want 13579bdf 0", rd, bd);
    end
  endtask

  task automatic test_faults;
    logic [31:0] rd;
    logic        bd;
    acc0(1'b0, MEM_TYPE_W, 32'h12, 32'h0, rd, bd);
    n_cmp++;
    if (rd !== 32'h0 || bd !== 1'b1) begin
      n_fail++; $display("FAIL lw_misalign: got rdata=%h bad=%b, want 0 1", rd, bd);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bad0 !== 1'b0) begin
      n_fail++; $display("FAIL bad_one_cycle: got bad=%b, want 0", bad0);
    end
    acc0(1'b1, MEM_TYPE_H, 32'h11, 32'h0000_1234, rd, bd);
    n_cmp++;
    if (bd !== 1'b1) begin
      n_fail++; $display("FAIL sh_misalign: got bad=%b, want 1", bd);
    end
    acc0(1'b1, MEM_TYPE_W, 32'h4000, 32'hFFFF_FFFF, rd, bd);
    acc0(1'b0, MEM_TYPE_W, 32'h4000, 32'h0, rd, bd);
    n_cmp++;
    if (rd !== 32'h0 || bd !== 1'b1) begin
      n_fail++; $display("FAIL lw_range: got rdata=%h bad=%b, want 0 1", rd, bd);
    end
    acc0(1'b0, 3'd3, 32'h10, 32'h0, rd, bd);
    n_cmp++;
    if (rd !== 32'h0 || bd !== 1'b1) begin
      n_fail++; $display("FAIL illegal_size: got rdata=%h bad=%b, want 0 1", rd, bd);
    end
    acc0(1'b0, MEM_TYPE_W, 32'h10, 32'h0, rd, bd);
    n_cmp++;
    if (rd !== 32'hDEAD_5AEF || bd !== 1'b0) begin
      n_fail++; $display("FAIL fault_no_write: got rdata=%h bad=%b, want dead5aef 0", rd, bd);
    end
    acc0(1'b0, MEM_TYPE_W, 32'h0, 32'h0, rd, bd);
    n_cmp++;
    if (rd === 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL range_no_wrap: got rdata=%h at word 0, want not ffffffff", rd);
    end
  endtask

  task automatic test_wait_states;
    logic [31:0] rd;
    logic        bd;
    int          nw;
    acc3(1'b1, MEM_TYPE_W, 32'h20, 32'h1122_3344, rd, bd, nw);
    n_cmp++;
    if (nw !== 3) begin
      n_fail++; $display("FAIL sw_wait_count: got %0d wait cycles, want 3", nw);
    end
    @(negedge clk);
    en3 = 1'b1; wen3 = 1'b0; size3 = MEM_TYPE_W; addr3 = 32'h20;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (wait3 !== 1'b1 || rd3 !== 32'h0) begin
        n_fail++; $display("FAIL hold_wait_%0d: got wait=%b rdata=%h, want 1 0", c, wait3, rd3);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (wait3 !== 1'b0 || rd3 !== 32'h1122_3344) begin
      n_fail++; $display("FAIL hold_data: got wait=%b rdata=%h, want 0 11223344", wait3, rd3);
    end
    @(negedge clk);
    en3 = 1'b0;
    #1;
    n_cmp++;
    if (wait3 !== 1'b1 || rd3 !== 32'h0) begin
      n_fail++; $display("FAIL second_accept: got wait=%b rdata=%h, want 1 0", wait3, rd3);
    end
    nw = 0;
    while (wait3 === 1'b1 && nw < 20) begin
      nw++;
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (nw !== 3 || rd3 !== 32'h1122_3344) begin
      n_fail++; $display("FAIL second_data: got %0d waits rdata=%h, want 3 11223344", nw, rd3);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (wait3 !== 1'b0 || rd3 !== 32'h0) begin
      n_fail++; $display("FAIL after_idle: got wait=%b rdata=%h, want 0 0", wait3, rd3);
    end
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd;
    logic        bd;
    int          nw;
    @(negedge clk);
    en3 = 1'b1; wen3 = 1'b1; size3 = MEM_TYPE_W; addr3 = 32'h20;
    @(negedge clk);
    en3 = 1'b0; wd3 = 32'hCAFE_F00D; reset = 1'b1;
    #1;
    n_cmp++;
    if ({rd3, wait3, bad3} !== 34'h0 || {rd0, wait0, bad0} !== 34'h0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got wait3=%b rdata3=%h, want all 0", wait3, rd3);
    end
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if ({rd3, wait3, bad3} !== 34'h0) begin
      n_fail++; $display("FAIL reset_hold_outputs: got wait3=%b rdata3=%h bad3=%b, want all 0", wait3, rd3, bad3);
    end
    reset = 1'b0;
    acc3(1'b0, MEM_TYPE_W, 32'h20, 32'h0, rd, bd, nw);
    n_cmp++;
    if (rd !== 32'h1122_3344 || bd !== 1'b0 || nw !== 3) begin
      n_fail++; $display("FAIL reset_no_write: got rdata=%h bad=%b waits=%0d, want 11223344 0 3", rd, bd, nw);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_lanes();
    test_store_byte();
    test_faults();
    test_wait_states();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
